// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: fetches one frame of words from an Avalon-MM burst read
// port (f2h_sdram style) and streams it out through an output FIFO with
// start/end-of-frame markers. Reads are only issued when the FIFO is
// guaranteed to have room for every word already in flight plus the new burst.
module sdram_frame_reader #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [23:0]       frame_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [4:0]        avm_burstcount,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Wide enough for fifo occupancy + outstanding + one burst (< 4*FIFO_DEPTH).
    localparam int CNT_W = PTR_W + 2;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_ISSUE       = 2'd1;
    localparam logic [1:0] S_WAIT_CREDIT = 2'd2;
    localparam logic [1:0] S_DRAIN       = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       req_left;     // words not yet requested
    logic [23:0]       pop_left;     // words not yet delivered on the stream
    logic              sof_pending;
    logic              done_r;
    logic [CNT_W-1:0]  outstanding;  // words requested but not yet returned
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [4:0] next_bc;
    logic       credit_ok;
    logic       accept;
    logic       push;
    logic       pop;
    logic       last_pop;

    assign next_bc   = (req_left >= 24'(BURST_LEN)) ? 5'(BURST_LEN) : req_left[4:0];
    // Occupancy + in-flight can only shrink while a request waits, so once
    // credit is granted it stays valid until the burst is accepted.
    assign credit_ok = (fifo_cnt + outstanding + CNT_W'(next_bc)) <= CNT_W'(FIFO_DEPTH);
    assign accept    = avm_read && !avm_waitrequest;
    // Beats with nothing outstanding are orphans of a burst aborted by reset.
    assign push      = avm_readdatavalid && (state != S_IDLE) && (outstanding != '0);
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && (pop_left == 24'd1);

    assign busy           = (state != S_IDLE);
    assign done           = done_r;
    assign avm_read       = (state == S_ISSUE);
    assign avm_address    = addr;
    assign avm_burstcount = (state == S_ISSUE) ? next_bc : 5'd0;
    assign out_valid      = (fifo_cnt != '0);
    assign out_data       = mem[rd_ptr];
    assign out_sof        = out_valid && sof_pending;
    assign out_eof        = out_valid && (pop_left == 24'd1);

    // Frame control FSM: request bursts under credit, then wait for the stream to drain.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would leak new values into later lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            req_left    <= '0;
            pop_left    <= '0;
            sof_pending <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (pop) begin
                pop_left    <= pop_left - 24'd1;
                sof_pending <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_words == 24'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state       <= S_ISSUE;
                            addr        <= base_addr;
                            req_left    <= frame_words;
                            pop_left    <= frame_words;
                            sof_pending <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        addr     <= addr + ADDR_W'(next_bc);
                        req_left <= req_left - 24'(next_bc);
                        state    <= (req_left == 24'(next_bc)) ? S_DRAIN : S_WAIT_CREDIT;
                    end
                end
                S_WAIT_CREDIT: begin
                    if (credit_ok) state <= S_ISSUE;
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // In-flight word count and FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding
                           + (accept ? CNT_W'(next_bc) : '0)
                           - (push ? CNT_W'(1) : '0);
            fifo_cnt    <= fifo_cnt + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage write port.
    // NOTE: the data array has no reset; emptiness is defined by fifo_cnt, so
    // clearing the storage would only cost reset fan-out and block RAM inference.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

endmodule

// File: doc/sdram_frame_reader.md
SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 29, word address width of the read port.
REQ-002 SHALL have parameter DATA_W, default 64, read data and stream data width.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum burstcount per request (power of 2, at least 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, output FIFO depth in words (power of 2, at least 2*BURST_LEN).
REQ-005 SHALL have port clk, input, 1, single block clock; all logic is in this domain.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle frame-fetch request.
REQ-008 SHALL have port base_addr, input, ADDR_W, first word address of the frame, sampled on an accepted start.
REQ-009 SHALL have port frame_words, input, 24, frame length in words, sampled on an accepted start.
REQ-010 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last word is accepted on the stream.
REQ-012 SHALL have ports avm_address, output, ADDR_W; avm_burstcount, output, 5; avm_read, output, 1.
REQ-013 SHALL have ports avm_waitrequest, input, 1; avm_readdata, input, DATA_W; avm_readdatavalid, input, 1 (f2h_sdram read slave).
REQ-014 SHALL have ports out_data, output, DATA_W; out_valid, output, 1; out_ready, input, 1; out_sof, output, 1; out_eof, output, 1.

Function
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 SHALL use FSM states IDLE, ISSUE, WAIT_CREDIT, DRAIN.
- IDLE -> ISSUE on start with frame_words != 0.
- ISSUE -> WAIT_CREDIT when a burst is accepted and words remain to request.
- ISSUE -> DRAIN when the final burst is accepted.
- WAIT_CREDIT -> ISSUE when credit is available.
- DRAIN -> IDLE when the last word is popped.
REQ-017 SHALL, when start arrives with frame_words == 0, issue no reads and pulse done exactly 1 cycle after start; busy stays low.
REQ-018 SHALL set burstcount = min(BURST_LEN, words not yet requested); avm_address starts at base_addr and advances by each accepted burstcount.
REQ-019 SHALL hold avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1; a request is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-020 SHALL assert avm_read only when FIFO occupancy plus outstanding words plus burstcount <= FIFO_DEPTH; the FIFO never overflows.
REQ-021 SHALL track outstanding words: +burstcount on accept, -1 per readdatavalid; simultaneous accept and valid both apply in the same cycle.
REQ-022 SHALL push every readdatavalid word into the FIFO the same cycle, with no data loss under any out_ready pattern.
REQ-023 SHALL make out_valid high when the FIFO is non-empty; a pop occurs on out_valid and out_ready; out_data is held while out_valid=1 and out_ready=0.
REQ-024 SHALL assert out_sof with the frame's first word and out_eof with word frame_words-1; both are qualified by out_valid.
REQ-025 SHALL have a minimum latency from start to first out_valid of 2 cycles plus the slave read latency (first readdatavalid -> out_valid next cycle).
REQ-026 SHALL wrap avm_address modulo 2^ADDR_W without error.
REQ-027 SHALL drive the handshake so that simultaneous FIFO push and pop keeps occupancy unchanged.

Reset
REQ-028 SHALL, on reset_n low at any time including mid-burst, asynchronously clear the FSM to IDLE and drive busy, done, avm_read, out_valid, out_sof, out_eof to 0, avm_address and avm_burstcount to 0, and empty the FIFO and all counters.
REQ-029 SHALL, after reset release, discard readdatavalid beats arriving in IDLE (orphans of an aborted burst).

Verification
REQ-030 SHALL cover this scenario: base_addr=0x100, frame_words=40, BURST_LEN=16, out_ready=1 -> bursts (0x100,16), (0x110,16), (0x120,8); 40 words are output in order; sof on word 0; eof on word 39; one done pulse.
REQ-031 SHALL cover this scenario: frame_words=0 -> no avm_read; done 1 cycle after start.
REQ-032 SHALL cover this scenario: out_ready=0 for the whole frame of 200 words, FIFO_DEPTH=64 -> exactly 64 words requested; avm_read stays low; on release all 200 words arrive intact.
REQ-033 SHALL cover this scenario: random waitrequest (50%) and random out_ready -> address and burstcount are stable during wait; data matches memory model; no overflow.
REQ-034 SHALL cover this scenario: reset_n asserted mid second burst -> all outputs are 0 within the same cycle; a new start after release fetches the full frame correctly.
REQ-035 SHALL cover this scenario: start pulsed while busy -> ignored; exactly one done pulse per accepted start.
